// File: rtl/banked_prog_mem_loader.sv
// banked_prog_mem_loader: multi-bank byte-wide program/sample RAM filled over
// the HPS ioctl download channel, with a CPU read/write port gated per bank.
// Optional feature macro: PROG_MEM_CHECKSUM_EN (8-bit additive checksum of
// accepted download bytes; without it o_checksum is tied to zero).
module banked_prog_mem_loader #(
    parameter int          ADDR_WIDTH = 13,
    parameter int          NUM_BANKS  = 4,
    parameter logic [7:0]  FILL_BYTE  = 8'h00,
    localparam int         BANK_BITS  = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [BANK_BITS-1:0]  i_bank_sel,
    input  logic [7:0]            i_data_in,
    input  logic                  i_rd,
    input  logic                  i_we,
    output logic [7:0]            o_data_out,
    input  logic                  i_ioctl_download,
    input  logic [7:0]            i_ioctl_index,
    input  logic                  i_ioctl_wr,
    input  logic [24:0]           i_ioctl_addr,
    input  logic [7:0]            i_ioctl_data,
    output logic                  o_ioctl_wait,
    output logic [NUM_BANKS-1:0]  o_bank_loaded,
    output logic                  o_load_busy,
    output logic [ADDR_WIDTH:0]   o_load_bytes,
    output logic                  o_load_overflow,
    output logic [7:0]            o_checksum
);

    localparam int                  DEPTH   = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] LB_MAX  = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [8:0]          IDX_LIM = 9'(NUM_BANKS);
    localparam logic [BANK_BITS:0]  SEL_LIM = (BANK_BITS+1)'(NUM_BANKS);
    localparam int                  MA_W    = BANK_BITS + ADDR_WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

    state_t                  r_state;
    logic                    r_dl_prev;
    logic [BANK_BITS-1:0]    r_tgt;
    logic [NUM_BANKS-1:0]    r_loaded;
    logic [ADDR_WIDTH:0]     r_bytes;
    logic                    r_ovf;
    logic                    r_wait;
    logic [7:0]              r_dout;
    logic [7:0]              r_mem [0:NUM_BANKS*DEPTH-1];

    logic                    w_dl_rise;
    logic                    w_idx_ok;
    logic                    w_dl_inrange;
    logic                    w_dl_acc;
    logic                    w_dl_we;
    logic                    w_sel_ok;
    logic [2**BANK_BITS-1:0] w_loaded_ext;
    logic                    w_sel_busy;
    logic                    w_cpu_ok;
    logic                    w_cpu_we;
    logic                    w_mem_we;
    logic [MA_W-1:0]         w_wr_addr;
    logic [7:0]              w_wr_data;
    logic [MA_W-1:0]         w_rd_addr;

    // Download side: edge detect, index range check, byte acceptance
    assign w_dl_rise    = i_ioctl_download & ~r_dl_prev;
    assign w_idx_ok     = {1'b0, i_ioctl_index} < IDX_LIM;
    assign w_dl_inrange = ~|i_ioctl_addr[24:ADDR_WIDTH];
    assign w_dl_acc     = (r_state == S_LOAD) & i_ioctl_wr;
    assign w_dl_we      = w_dl_acc & w_dl_inrange;

    // CPU side: bank must exist, be loaded, and not be the live load target.
    // Widening the flag vector keeps the index in range for odd bank counts.
    assign w_sel_ok     = {1'b0, i_bank_sel} < SEL_LIM;
    assign w_loaded_ext = (2**BANK_BITS)'(r_loaded);
    assign w_sel_busy   = (r_state == S_LOAD) && (i_bank_sel == r_tgt);
    assign w_cpu_ok     = w_sel_ok && w_loaded_ext[i_bank_sel] && !w_sel_busy;
    // A download byte owns the single write port; a colliding CPU write is lost
    assign w_cpu_we     = i_we && w_cpu_ok && !w_dl_we;
    assign w_mem_we     = w_dl_we | w_cpu_we;
    assign w_wr_addr    = w_dl_we ? {r_tgt, i_ioctl_addr[ADDR_WIDTH-1:0]} : {i_bank_sel, i_addr};
    assign w_wr_data    = w_dl_we ? i_ioctl_data : i_data_in;
    assign w_rd_addr    = {i_bank_sel, i_addr};

    // Memory write port, no reset so the array maps onto block RAM
    always_ff @(posedge i_clk) begin
        if (w_mem_we)
            r_mem[w_wr_addr] <= w_wr_data;
    end

    // Registered CPU read; old contents are returned on a same-address write
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n)
            r_dout <= 8'h00;
        else if (i_rd)
            r_dout <= w_cpu_ok ? r_mem[w_rd_addr] : FILL_BYTE;
    end

    // Loader FSM with its status registers
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state   <= S_IDLE;
            r_dl_prev <= 1'b0;
            r_tgt     <= '0;
            r_loaded  <= '0;
            r_bytes   <= '0;
            r_ovf     <= 1'b0;
            r_wait    <= 1'b0;
        end else begin
            r_dl_prev <= i_ioctl_download;
            r_wait    <= w_dl_acc;
            case (r_state)
                S_IDLE: begin
                    if (w_dl_rise && w_idx_ok) begin
                        r_tgt <= i_ioctl_index[BANK_BITS-1:0];
                        r_loaded[i_ioctl_index[BANK_BITS-1:0]] <= 1'b0;
                        r_bytes <= '0;
                        r_ovf   <= 1'b0;
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (w_dl_acc) begin
                        if (w_dl_inrange) begin
                            if (r_bytes != LB_MAX)
                                r_bytes <= r_bytes + (ADDR_WIDTH+1)'(1);
                        end else begin
                            r_ovf <= 1'b1;
                        end
                    end
                    if (!i_ioctl_download)
                        r_state <= S_DONE;
                end
                S_DONE: begin
                    // An empty download leaves the bank marked unloaded
                    r_loaded[r_tgt] <= (r_bytes != '0);
                    r_state         <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef PROG_MEM_CHECKSUM_EN
    logic [7:0] r_csum;

    // Running mod-256 sum of accepted bytes, cleared when a load starts
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n)
            r_csum <= 8'h00;
        else if (r_state == S_IDLE && w_dl_rise && w_idx_ok)
            r_csum <= 8'h00;
        else if (w_dl_we)
            r_csum <= r_csum + i_ioctl_data;
    end

    assign o_checksum = r_csum;
`else
    assign o_checksum = 8'h00;
`endif

    assign o_data_out      = r_dout;
    assign o_ioctl_wait    = r_wait;
    assign o_bank_loaded   = r_loaded;
    assign o_load_busy     = (r_state == S_LOAD);
    assign o_load_bytes    = r_bytes;
    assign o_load_overflow = r_ovf;

endmodule

// File: tb/tb_banked_prog_mem_loader.sv
// Bench for banked_prog_mem_loader: directed table of CPU accesses, hand
// sequences for download corner cases, then random traffic checked against a
// transaction-level model of the banks.
module tb_banked_prog_mem_loader;

    localparam int         AW    = 13;
    localparam int         NB    = 4;
    localparam int         DEPTH = 8192;
    localparam logic [7:0] FILL  = 8'h00;

    logic          i_clk = 1'b0;
    logic          i_reset_n;
    logic [AW-1:0] i_addr;
    logic [1:0]    i_bank_sel;
    logic [7:0]    i_data_in;
    logic          i_rd, i_we;
    logic [7:0]    o_data_out;
    logic          i_ioctl_download;
    logic [7:0]    i_ioctl_index;
    logic          i_ioctl_wr;
    logic [24:0]   i_ioctl_addr;
    logic [7:0]    i_ioctl_data;
    logic          o_ioctl_wait;
    logic [NB-1:0] o_bank_loaded;
    logic          o_load_busy;
    logic [AW:0]   o_load_bytes;
    logic          o_load_overflow;
    logic [7:0]    o_checksum;

    banked_prog_mem_loader #(.ADDR_WIDTH(AW), .NUM_BANKS(NB), .FILL_BYTE(FILL)) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_addr(i_addr), .i_bank_sel(i_bank_sel),
        .i_data_in(i_data_in), .i_rd(i_rd), .i_we(i_we), .o_data_out(o_data_out),
        .i_ioctl_download(i_ioctl_download), .i_ioctl_index(i_ioctl_index),
        .i_ioctl_wr(i_ioctl_wr), .i_ioctl_addr(i_ioctl_addr), .i_ioctl_data(i_ioctl_data),
        .o_ioctl_wait(o_ioctl_wait), .o_bank_loaded(o_bank_loaded), .o_load_busy(o_load_busy),
        .o_load_bytes(o_load_bytes), .o_load_overflow(o_load_overflow), .o_checksum(o_checksum)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;

    // Reference model: bank contents and load status as seen by software
    logic [7:0] m_mem [0:NB-1][0:DEPTH-1];
    bit         m_loaded [NB];
    int         m_bytes;
    bit         m_ovf;
    logic [7:0] m_csum;
    logic [7:0] m_dout;

    // Download byte lists consumed by dl_run
    int         dl_a[$];
    logic [7:0] dl_d[$];

    typedef struct {
        int         bank;
        int         addr;
        bit         rd;
        bit         we;
        logic [7:0] din;
        logic [7:0] exp;
    } vec_t;
    vec_t vt[13];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    function automatic logic [NB-1:0] m_loaded_vec();
        logic [NB-1:0] v;
        for (int i = 0; i < NB; i++) v[i] = m_loaded[i];
        return v;
    endfunction

    function automatic logic [7:0] exp_csum();
`ifdef PROG_MEM_CHECKSUM_EN
        return m_csum;
`else
        return 8'h00;
`endif
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NB; i++) m_loaded[i] = 1'b0;
        m_bytes = 0;
        m_ovf   = 1'b0;
        m_csum  = 8'h00;
        m_dout  = 8'h00;
    endtask

    task automatic check_status(input string tag);
        chk({tag, "_loaded"}, 32'(o_bank_loaded), 32'(m_loaded_vec()));
        chk({tag, "_bytes"}, 32'(o_load_bytes), m_bytes);
        chk({tag, "_ovf"}, 32'(o_load_overflow), 32'(m_ovf));
        chk({tag, "_csum"}, 32'(o_checksum), 32'(exp_csum()));
    endtask

    // Model effect of one accepted (or dropped) download byte
    task automatic model_byte(input int idx, input int a, input logic [7:0] d);
        if (a < DEPTH) begin
            m_mem[idx][a] = d;
            if (m_bytes < DEPTH) m_bytes++;
            m_csum = m_csum + d;
        end else begin
            m_ovf = 1'b1;
        end
    endtask

    // Full download of the queued bytes, one gap cycle between strobes
    task automatic dl_run(input int idx, input bit chk_wait, input string tag);
        bit valid;
        valid = (idx < NB);
        i_ioctl_index    = 8'(idx);
        i_ioctl_download = 1'b1;
        tick();
        if (valid) begin
            m_loaded[idx] = 1'b0;
            m_bytes = 0;
            m_ovf   = 1'b0;
            m_csum  = 8'h00;
        end
        chk({tag, "_busy"}, 32'(o_load_busy), 32'(valid));
        for (int i = 0; i < dl_a.size(); i++) begin
            i_ioctl_wr   = 1'b1;
            i_ioctl_addr = 25'(dl_a[i]);
            i_ioctl_data = dl_d[i];
            tick();
            i_ioctl_wr = 1'b0;
            if (chk_wait) chk({tag, "_wait_hi"}, 32'(o_ioctl_wait), 32'(valid));
            if (valid) model_byte(idx, dl_a[i], dl_d[i]);
            tick();
            if (chk_wait) chk({tag, "_wait_lo"}, 32'(o_ioctl_wait), 0);
        end
        i_ioctl_download = 1'b0;
        tick();
        tick();
        if (valid) m_loaded[idx] = (m_bytes != 0);
        chk({tag, "_busy_end"}, 32'(o_load_busy), 0);
        check_status(tag);
        dl_a.delete();
        dl_d.delete();
    endtask

    task automatic cpu_op(input int bank, input int addr, input bit rd, input bit we,
                          input logic [7:0] din, output logic [7:0] got);
        i_bank_sel = bank[1:0];
        i_addr     = addr[AW-1:0];
        i_rd       = rd;
        i_we       = we;
        i_data_in  = din;
        tick();
        i_rd = 1'b0;
        i_we = 1'b0;
        got  = o_data_out;
        if (rd) m_dout = (bank < NB && m_loaded[bank]) ? m_mem[bank][addr] : FILL;
        if (we && bank < NB && m_loaded[bank]) m_mem[bank][addr] = din;
    endtask

    initial begin
        logic [7:0] got;
        int         n;

        vt[0]  = '{1, 0, 1'b1, 1'b0, 8'h00, 8'hC3};
        vt[1]  = '{1, 1, 1'b1, 1'b0, 8'h00, 8'h00};
        vt[2]  = '{1, 2, 1'b1, 1'b0, 8'h00, 8'h10};
        vt[3]  = '{1, 3, 1'b0, 1'b1, 8'h5A, 8'h10};
        vt[4]  = '{1, 3, 1'b1, 1'b0, 8'h00, 8'h5A};
        vt[5]  = '{0, 0, 1'b1, 1'b0, 8'h00, 8'h00};
        vt[6]  = '{0, 0, 1'b0, 1'b1, 8'h77, 8'h00};
        vt[7]  = '{1, 2, 1'b1, 1'b1, 8'h99, 8'h10};
        vt[8]  = '{1, 2, 1'b1, 1'b0, 8'h00, 8'h99};
        vt[9]  = '{1, 5, 1'b0, 1'b1, 8'h11, 8'h99};
        vt[10] = '{0, 0, 1'b1, 1'b0, 8'h00, 8'h00};
        vt[11] = '{3, 0, 1'b1, 1'b0, 8'h00, 8'h00};
        vt[12] = '{1, 5, 1'b1, 1'b0, 8'h00, 8'h11};

        i_reset_n = 1'b0;
        i_addr = '0; i_bank_sel = '0; i_data_in = '0; i_rd = 1'b0; i_we = 1'b0;
        i_ioctl_download = 1'b0; i_ioctl_index = '0; i_ioctl_wr = 1'b0;
        i_ioctl_addr = '0; i_ioctl_data = '0;
        model_reset();
        #23;
        chk("rst_dout", 32'(o_data_out), 0);
        chk("rst_wait", 32'(o_ioctl_wait), 0);
        chk("rst_busy", 32'(o_load_busy), 0);
        check_status("rst");
        i_reset_n = 1'b1;
        tick();

        // Reset-state read of an unloaded bank
        cpu_op(0, 0, 1'b1, 1'b0, 8'h00, got);
        chk("t1_rd_fill", 32'(got), 32'(FILL));

        // Three-byte image into bank 1
        dl_a = '{0, 1, 2};
        dl_d = '{8'hC3, 8'h00, 8'h10};
        dl_run(1, 1'b1, "t2");
        chk("t2_loaded_const", 32'(o_bank_loaded), 32'h2);
        chk("t2_bytes_const", 32'(o_load_bytes), 3);
`ifdef PROG_MEM_CHECKSUM_EN
        chk("t2_csum_const", 32'(o_checksum), 32'hD3);
`else
        chk("t2_csum_const", 32'(o_checksum), 0);
`endif

        // Directed CPU accesses: gating, hold, read-first
        for (int i = 0; i < 13; i++) begin
            cpu_op(vt[i].bank, vt[i].addr, vt[i].rd, vt[i].we, vt[i].din, got);
            chk($sformatf("vec%0d", i), 32'(got), 32'(vt[i].exp));
        end

        // Out-of-range download byte only sets overflow
        dl_a = '{8192};
        dl_d = '{8'hFF};
        dl_run(2, 1'b1, "t3");
        chk("t3_ovf_const", 32'(o_load_overflow), 1);
        cpu_op(2, 0, 1'b1, 1'b0, 8'h00, got);
        chk("t3_rd_fill", 32'(got), 32'(FILL));

        // Download byte and CPU write in the same cycle
        i_ioctl_index = 8'd0;
        i_ioctl_download = 1'b1;
        tick();
        m_loaded[0] = 1'b0; m_bytes = 0; m_ovf = 1'b0; m_csum = 8'h00;
        i_ioctl_wr = 1'b1; i_ioctl_addr = 25'd5; i_ioctl_data = 8'hAA;
        i_we = 1'b1; i_bank_sel = 2'd1; i_addr = 13'd5; i_data_in = 8'h55;
        tick();
        i_ioctl_wr = 1'b0; i_we = 1'b0;
        model_byte(0, 5, 8'hAA);
        chk("t4_wait", 32'(o_ioctl_wait), 1);
        i_ioctl_download = 1'b0;
        tick();
        tick();
        m_loaded[0] = 1'b1;
        check_status("t4");
        cpu_op(0, 5, 1'b1, 1'b0, 8'h00, got);
        chk("t4_bank0", 32'(got), 32'hAA);
        cpu_op(1, 5, 1'b1, 1'b0, 8'h00, got);
        chk("t4_bank1", 32'(got), 32'h11);

        // Reset in the middle of a load of bank 3
        i_ioctl_index = 8'd3;
        i_ioctl_download = 1'b1;
        tick();
        for (int i = 0; i < 2; i++) begin
            i_ioctl_wr = 1'b1; i_ioctl_addr = 25'(i); i_ioctl_data = 8'(8'h40 + i);
            tick();
            m_mem[3][i] = 8'(8'h40 + i);
        end
        i_ioctl_wr = 1'b0;
        #2 i_reset_n = 1'b0;
        #1;
        model_reset();
        chk("t5_busy", 32'(o_load_busy), 0);
        chk("t5_wait", 32'(o_ioctl_wait), 0);
        check_status("t5");
        i_ioctl_download = 1'b0;
        tick();
        i_reset_n = 1'b1;
        tick();
        chk("t5_idle", 32'(o_load_busy), 0);

        // Out-of-range index: nothing must reach bank 3 (index 7 aliases it)
        dl_a = '{0};
        dl_d = '{8'h31};
        dl_run(3, 1'b1, "t6pre");
        dl_a = '{0};
        dl_d = '{8'hEE};
        dl_run(7, 1'b1, "t6");
        cpu_op(3, 0, 1'b1, 1'b0, 8'h00, got);
        chk("t6_rd", 32'(got), 32'h31);

        // Byte counter saturation on a full-bank image plus one extra byte
        for (int i = 0; i <= DEPTH; i++) begin
            dl_a.push_back(i % DEPTH);
            dl_d.push_back(8'($urandom));
        end
        dl_run(2, 1'b0, "sat");
        chk("sat_bytes", 32'(o_load_bytes), DEPTH);

        // Known contents in the low addresses of every bank before random traffic
        for (int b = 0; b < NB; b++) begin
            for (int a = 0; a < 16; a++) begin
                dl_a.push_back(a);
                dl_d.push_back(8'($urandom));
            end
            dl_run(b, 1'b0, "init");
        end

        for (int it = 0; it < 300; it++) begin
            if ($urandom_range(0, 9) == 0) begin
                n = $urandom_range(0, 4);
                for (int k = 0; k < n; k++) begin
                    dl_a.push_back(($urandom_range(0, 7) == 0) ? DEPTH + $urandom_range(0, 3)
                                                               : $urandom_range(0, 15));
                    dl_d.push_back(8'($urandom));
                end
                dl_run($urandom_range(0, 5), 1'b1, "rnd_dl");
            end else begin
                cpu_op($urandom_range(0, 3), $urandom_range(0, 15), 1'($urandom),
                       1'($urandom), 8'($urandom), got);
                chk("rnd_rd", 32'(got), 32'(m_dout));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
